// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush and MEM-busy freeze.
// Define HAZARD_STATS_EN to build the saturating stall/bubble statistics counters.
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [RAW-1:0]  id_rs1_i,
  input  logic [RAW-1:0]  id_rs2_i,
  input  logic            id_uses_rs2_i,
  input  logic [RAW-1:0]  id_rd_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [7:0]      id_ctrl_i,
  input  logic            flush_i,
  input  logic            mem_busy_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RAW-1:0]  ex_rs1_o,
  output logic [RAW-1:0]  ex_rs2_o,
  output logic [RAW-1:0]  ex_rd_o,
  output logic [7:0]      ex_ctrl_o,
  output logic            stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int MEMREAD = 6;

  logic flush_pend;
  logic flush_eff;
  logic hazard;
  logic load_bubble;

  assign hazard = ex_valid_o && ex_ctrl_o[MEMREAD] && (ex_rd_o != '0) && id_valid_i &&
                  ((ex_rd_o == id_rs1_i) || (id_uses_rs2_i && (ex_rd_o == id_rs2_i)));
  assign flush_eff   = flush_i | flush_pend;
  assign stall_o     = mem_busy_i | (hazard & ~flush_eff);
  assign load_bubble = ~mem_busy_i & (flush_eff | hazard);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_ctrl_o     <= '0;
      flush_pend    <= 1'b0;
    end else if (mem_busy_i) begin
      // Freeze: a flush arriving now must not be lost, so remember it.
      if (flush_i) flush_pend <= 1'b1;
    end else if (load_bubble) begin
      // Bubble has rd=0 so the forwarding unit never matches it.
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_ctrl_o     <= '0;
      flush_pend    <= 1'b0;
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_rd_i;
      ex_ctrl_o     <= id_ctrl_i;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_o && (stall_cnt != '1))        stall_cnt  <= stall_cnt + 1'b1;
      if (load_bubble && (bubble_cnt != '1))   bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, load-use, x0, rs2-only, flush, freeze+flush, stats.
module tb_id_ex_hazard_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_uses_rs2_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [7:0]  id_ctrl_i;
  logic        flush_i, mem_busy_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [7:0]  ex_ctrl_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o, bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] CTRL_LW  = 8'hD8; // regwrite, memread, memtoreg, alusrc
  localparam logic [7:0] CTRL_ADD = 8'h82; // regwrite, aluop=10

  always #5 clk_i = ~clk_i;

  id_ex_hazard_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .mem_busy_i(mem_busy_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data fields derive from pc so captured copies are easy to predict.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic [7:0] ctrl);
    id_valid_i    = v;
    id_pc_i       = pc;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_uses_rs2_i = u2;
    id_rd_i       = rd;
    id_rs1_data_i = pc ^ 32'hA5A5_0000;
    id_rs2_data_i = pc + 32'd1;
    id_imm_i      = pc >> 2;
    id_ctrl_i     = ctrl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    mem_busy_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom, 5'($urandom), 5'($urandom), $urandom_range(0, 1),
            5'($urandom), 8'($urandom));
      flush_i    = $urandom_range(0, 1);
      mem_busy_i = $urandom_range(0, 1);
      step();
    end
    rst_i = 1'b0; flush_i = 1'b0; mem_busy_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00);
    #1;
    check("rst_valid", ex_valid_o, 0);
    check("rst_pc",    ex_pc_o, 0);
    check("rst_rd",    ex_rd_o, 0);
    check("rst_ctrl",  ex_ctrl_o, 0);
    check("rst_data",  ex_rs1_data_o, 0);
    check("rst_stall", stall_o, 0);

    // Load-use: lw x5 then add x6,x5,x1
    drive(1'b1, 32'h100, 5'd2, 5'd0, 1'b0, 5'd5, CTRL_LW);
    #1 check("lw_nostall", stall_o, 0);
    step();
    check("lw_valid", ex_valid_o, 1);
    check("lw_rd",    ex_rd_o, 5);
    check("lw_ctrl",  ex_ctrl_o, CTRL_LW);
    drive(1'b1, 32'h104, 5'd5, 5'd1, 1'b1, 5'd6, CTRL_ADD);
    #1 check("lu_stall", stall_o, 1);
    step();
    check("lu_bub_valid", ex_valid_o, 0);
    check("lu_bub_ctrl",  ex_ctrl_o, 0);
    check("lu_bub_rd",    ex_rd_o, 0);
    check("lu_bub_pc",    ex_pc_o, 0);
    check("lu_stall_gone", stall_o, 0);
    step();
    check("add_valid", ex_valid_o, 1);
    check("add_rs1",   ex_rs1_o, 5);
    check("add_pc",    ex_pc_o, 32'h104);
    check("add_d2",    ex_rs2_data_o, 32'h105);
    check("add_imm",   ex_imm_o, 32'h41);

    // rs2 field matches but instruction does not read rs2
    drive(1'b1, 32'h108, 5'd2, 5'd0, 1'b0, 5'd5, CTRL_LW);
    step();
    drive(1'b1, 32'h10C, 5'd3, 5'd5, 1'b0, 5'd6, CTRL_ADD);
    #1 check("rs2only_stall", stall_o, 0);
    step();
    check("rs2only_pc", ex_pc_o, 32'h10C);

    // lw x0 followed by a reader of x0
    drive(1'b1, 32'h200, 5'd2, 5'd0, 1'b0, 5'd0, CTRL_LW);
    step();
    drive(1'b1, 32'h204, 5'd0, 5'd0, 1'b1, 5'd7, CTRL_ADD);
    #1 check("x0_stall", stall_o, 0);
    step();
    check("x0_pc", ex_pc_o, 32'h204);

    // Flush wins over hazard
    drive(1'b1, 32'h300, 5'd2, 5'd0, 1'b0, 5'd5, CTRL_LW);
    step();
    drive(1'b1, 32'h304, 5'd5, 5'd1, 1'b1, 5'd6, CTRL_ADD);
    flush_i = 1'b1;
    #1 check("flush_stall", stall_o, 0);
    step();
    check("flush_bub_valid", ex_valid_o, 0);
    check("flush_bub_ctrl",  ex_ctrl_o, 0);
    flush_i = 1'b0;
    drive(1'b1, 32'h308, 5'd5, 5'd1, 1'b1, 5'd6, CTRL_ADD);
    #1 check("flush_no_extra", stall_o, 0);
    step();
    check("flush_next_pc", ex_pc_o, 32'h308);

    // Freeze 3 cycles with flush on the first
    mem_busy_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h30C, 5'd1, 5'd2, 1'b1, 5'd8, CTRL_ADD);
    #1 check("frz_stall", stall_o, 1);
    step();
    check("frz_hold1", ex_pc_o, 32'h308);
    flush_i = 1'b0;
    step();
    check("frz_hold2", ex_pc_o, 32'h308);
    step();
    check("frz_hold3", ex_pc_o, 32'h308);
    check("frz_hold_valid", ex_valid_o, 1);
    check("frz_hold_rd", ex_rd_o, 6);
    mem_busy_i = 1'b0;
    drive(1'b1, 32'h310, 5'd1, 5'd2, 1'b1, 5'd8, CTRL_ADD);
    #1 check("frz_release_stall", stall_o, 0);
    step();
    check("frz_bub_valid", ex_valid_o, 0);
    check("frz_bub_pc", ex_pc_o, 0);
    drive(1'b1, 32'h314, 5'd1, 5'd2, 1'b1, 5'd8, CTRL_ADD);
    step();
    check("pend_clear_pc", ex_pc_o, 32'h314);
    check("pend_clear_valid", ex_valid_o, 1);

    // Statistics: one load-use plus a 3-cycle freeze
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("stat_rst_stall", stall_cnt_o, 0);
    drive(1'b1, 32'h400, 5'd2, 5'd0, 1'b0, 5'd5, CTRL_LW);
    step();
    drive(1'b1, 32'h404, 5'd5, 5'd1, 1'b1, 5'd6, CTRL_ADD);
    step();
    step();
    mem_busy_i = 1'b1;
    step(); step(); step();
    mem_busy_i = 1'b0;
    drive(1'b0, 32'h408, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00);
    step();
    check("idle_valid", ex_valid_o, 0);
`ifdef HAZARD_STATS_EN
    check("stat_stall",  stall_cnt_o, 4);
    check("stat_bubble", bubble_cnt_o, 1);
`else
    check("stat_stall_tied",  stall_cnt_o, 0);
    check("stat_bubble_tied", bubble_cnt_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
